// File: rtl/bias_relu_stage.sv
// rtl/bias_relu_stage.sv - two-stage per-lane bias add, 18-bit saturation and optional ReLU
// S1 holds the 19-bit sums, S2 holds the final lane results, and both stages stall together on backpressure.
module bias_relu_stage #(
   parameter int N_adder_tree = 16,
   parameter int RELU_EN      = 1,
   parameter int N_PIX        = 49
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_adder_tree*18-1:0]   bias_q,
   input  logic [N_adder_tree*18-1:0]   in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [N_adder_tree*18-1:0]   out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         sat_flag
);
   localparam int W     = N_adder_tree * 18;
   localparam int CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PIX - 1);

   logic [N_adder_tree-1:0][18:0] s1_sum_q, s1_sum_d;
   logic                          s1_valid_q;
   logic [W-1:0]                  s2_data_q, s2_data_d;
   logic                          s2_valid_q;
   logic [CNT_W-1:0]              pix_cnt_q, pix_cnt_d;
   logic                          sat_q, sat_d;
   logic                          any_sat;
   logic                          s2_adv;
   logic [18:0]                   lane_sum;
   logic [17:0]                   lane_res;

   // S1 may always move into S2 whenever S2 is empty or being drained this cycle.
   assign s2_adv   = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_adv;

   always_comb begin
      s1_sum_d  = '0;
      s2_data_d = '0;
      any_sat   = 1'b0;
      lane_sum  = '0;
      lane_res  = '0;
      for (int i = 0; i < N_adder_tree; i++) begin
         s1_sum_d[i] = {in_data[18*i+17], in_data[18*i +: 18]}
                     + {bias_q[18*i+17], bias_q[18*i +: 18]};
         lane_sum = s1_sum_q[i];
         // The two top bits disagree exactly when the sum left the 18-bit range.
         if (lane_sum[18] != lane_sum[17]) begin
            any_sat  = 1'b1;
            lane_res = lane_sum[18] ? 18'h20000 : 18'h1FFFF;
         end else begin
            lane_res = lane_sum[17:0];
         end
         if (RELU_EN != 0 && lane_res[17]) begin
            lane_res = '0;
         end
         s2_data_d[18*i +: 18] = lane_res;
      end
   end

   assign sat_d     = sat_q | (s1_valid_q & any_sat);
   assign pix_cnt_d = (pix_cnt_q == LAST_CNT) ? '0 : pix_cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sum_q   <= '0;
         s1_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_valid_q <= 1'b0;
         pix_cnt_q  <= '0;
         sat_q      <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_sum_q <= s1_sum_d;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_data_q <= s2_data_d;
               sat_q     <= sat_d;
            end
         end
         if (s2_valid_q && out_ready) begin
            pix_cnt_q <= pix_cnt_d;
         end
      end
   end

   assign out_data  = s2_data_q;
   assign out_valid = s2_valid_q;
   assign out_last  = s2_valid_q && (pix_cnt_q == LAST_CNT);
   assign sat_flag  = sat_q;
endmodule
